// File: rtl/alu_operand_collector_if.sv
// Operand-collector bus: command/operand inputs from the stimulus side and the
// aligned packet handshake toward the ALU core. The collector uses "slave",
// whoever feeds it uses "master".
interface alu_operand_collector_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
);
    logic                 CE;
    logic [1:0]           INP_VALID;
    logic [WIDTH-1:0]     OPA;
    logic [WIDTH-1:0]     OPB;
    logic [CMD_WIDTH-1:0] CMD;
    logic                 MODE;
    logic                 CIN;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_opa;
    logic [WIDTH-1:0]     out_opb;
    logic [CMD_WIDTH-1:0] out_cmd;
    logic                 out_mode;
    logic                 out_cin;
    logic [1:0]           out_vmask;
    logic                 out_err;

    modport master (
        output CE, INP_VALID, OPA, OPB, CMD, MODE, CIN, out_ready,
        input  in_ready, out_valid, out_opa, out_opb, out_cmd, out_mode,
               out_cin, out_vmask, out_err
    );

    modport slave (
        input  CE, INP_VALID, OPA, OPB, CMD, MODE, CIN, out_ready,
        output in_ready, out_valid, out_opa, out_opb, out_cmd, out_mode,
               out_cin, out_vmask, out_err
    );
endinterface

// File: rtl/alu_operand_collector.sv
// ALU operand collector: gathers OPA/OPB (same or separate cycles), closes the
// packet when both arrive, when only one is needed, or on timeout, and holds it
// on a valid/ready handshake.
// Optional: define ALU_COLLECTOR_STATS_EN to add saturating packet/timeout counters.
module alu_operand_collector #(
    parameter int                          WIDTH     = 8,
    parameter int                          CMD_WIDTH = 4,
    parameter int                          TIMEOUT   = 16,
    parameter logic [(2**CMD_WIDTH)-1:0]   ARITH_2OP = 16'h0FFF,
    parameter logic [(2**CMD_WIDTH)-1:0]   LOGIC_2OP = 16'h003F
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_operand_collector_if.slave bus
`ifdef ALU_COLLECTOR_STATS_EN
    ,
    output logic [15:0]            stat_pkt_cnt,
    output logic [15:0]            stat_tmo_cnt
`endif
);

    // Timer only has to reach TIMEOUT-1, so it never needs to wrap.
    localparam int            TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_d, state_q;
    logic [1:0]           vmask_d, vmask_q;
    logic [TW-1:0]        timer_d, timer_q;
    logic                 err_d, err_q;
    logic [CMD_WIDTH-1:0] cmd_d, cmd_q;
    logic                 mode_d, mode_q;
    logic                 cin_d, cin_q;

    logic                 start;
    logic                 need2;
    logic [1:0]           merged;
    logic                 handshake;
    logic                 cap_first;
    logic                 cap_more;
    logic [WIDTH-1:0]     op_in  [2];
    logic [WIDTH-1:0]     lane_q [2];

    assign start     = bus.CE && (bus.INP_VALID != 2'b00);
    assign need2     = bus.MODE ? ARITH_2OP[bus.CMD] : LOGIC_2OP[bus.CMD];
    assign merged    = vmask_q | bus.INP_VALID;
    assign handshake = (state_q == ST_HOLD) && bus.out_ready;
    assign cap_first = (state_q == ST_IDLE) && start;
    assign cap_more  = (state_q == ST_WAIT) && bus.CE;

    assign op_in[0] = bus.OPA;
    assign op_in[1] = bus.OPB;

    // Next-state, command capture, operand mask and timeout tracking.
    always_comb begin
        state_d = state_q;
        vmask_d = vmask_q;
        timer_d = timer_q;
        err_d   = err_q;
        cmd_d   = cmd_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cmd_d   = bus.CMD;
                    mode_d  = bus.MODE;
                    cin_d   = bus.CIN;
                    vmask_d = bus.INP_VALID;
                    timer_d = '0;
                    err_d   = 1'b0;
                    if (!need2 || bus.INP_VALID == 2'b11) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.CE) begin
                    vmask_d = merged;
                    // A completing operand beats an expiring timer.
                    if (merged == 2'b11) begin
                        state_d = ST_HOLD;
                        err_d   = 1'b0;
                        timer_d = '0;
                    end else if (timer_q == TMO_LAST) begin
                        state_d = ST_HOLD;
                        err_d   = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            ST_HOLD: begin
                // out_ready is honoured even with CE low.
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    vmask_d = 2'b00;
                    err_d   = 1'b0;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and command registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            vmask_q <= 2'b00;
            timer_q <= '0;
            err_q   <= 1'b0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vmask_q <= vmask_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
        end
    end

    // One storage lane per operand; an unreceived operand is zeroed at
    // command capture so a timed-out packet shows 0 in the missing field.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [WIDTH-1:0] op_d;
            logic [WIDTH-1:0] op_q;

            // Load on first capture, or overwrite on a (re)qualified operand in WAIT.
            always_comb begin
                op_d = op_q;
                if (cap_first) begin
                    op_d = bus.INP_VALID[gi] ? op_in[gi] : '0;
                end else if (cap_more && bus.INP_VALID[gi]) begin
                    op_d = op_in[gi];
                end
            end

            // Operand lane register.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    op_q <= '0;
                end else begin
                    op_q <= op_d;
                end
            end

            assign lane_q[gi] = op_q;
        end
    endgenerate

    assign bus.in_ready  = (state_q != ST_HOLD);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_opa   = lane_q[0];
    assign bus.out_opb   = lane_q[1];
    assign bus.out_cmd   = cmd_q;
    assign bus.out_mode  = mode_q;
    assign bus.out_cin   = cin_q;
    assign bus.out_vmask = vmask_q;
    assign bus.out_err   = err_q;

`ifdef ALU_COLLECTOR_STATS_EN
    logic [15:0] pkt_cnt_d, pkt_cnt_q;
    logic [15:0] tmo_cnt_d, tmo_cnt_q;

    // Saturating counters of completed handshakes and timed-out handshakes.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        if (handshake) begin
            if (pkt_cnt_q != 16'hFFFF) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
            if (err_q && tmo_cnt_q != 16'hFFFF) begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_cnt_q <= 16'd0;
            tmo_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign stat_pkt_cnt = pkt_cnt_q;
    assign stat_tmo_cnt = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_collector.sv
// Testbench for alu_operand_collector: directed scenarios plus random traffic,
// expected packets queued by a transaction-level model and checked by a monitor.
module tb_alu_operand_collector;

    localparam int          TIMEOUT = 16;
    localparam logic [15:0] ARITH   = 16'h0FFF;
    localparam logic [15:0] LOGIC   = 16'h003F;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_operand_collector_if #(.WIDTH(8), .CMD_WIDTH(4)) bus ();

`ifdef ALU_COLLECTOR_STATS_EN
    logic [15:0] stat_pkt_cnt;
    logic [15:0] stat_tmo_cnt;
`endif

    alu_operand_collector #(
        .WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(TIMEOUT),
        .ARITH_2OP(ARITH), .LOGIC_2OP(LOGIC)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus.slave)
`ifdef ALU_COLLECTOR_STATS_EN
        ,
        .stat_pkt_cnt(stat_pkt_cnt),
        .stat_tmo_cnt(stat_tmo_cnt)
`endif
    );

    typedef struct {
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
        logic [1:0] vm;
        logic       err;
        int         exp_cyc;
    } pkt_t;

    pkt_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;
    bit seen   = 0;

    // Model of the collector at command level.
    bit         m_busy, m_pend, m_hold_err;
    logic [7:0] m_a, m_b;
    logic [3:0] m_cmd;
    logic       m_mode, m_cin;
    logic [1:0] m_vm;
    int         m_wait;
    int         m_pkts, m_tmos;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic emit(input bit e);
        pkt_t p;
        p.opa = m_a; p.opb = m_b; p.cmd = m_cmd; p.mode = m_mode; p.cin = m_cin;
        p.vm = m_vm; p.err = e; p.exp_cyc = cyc + 1;
        sb.push_back(p);
        m_busy = 1; m_pend = 0; m_hold_err = e;
    endtask

    // Predict the effect of the upcoming clock edge from the driven inputs.
    task automatic model_step();
        if (!rst_n) begin
            m_busy = 0; m_pend = 0; m_hold_err = 0;
            m_pkts = 0; m_tmos = 0;
            sb.delete();
            seen = 0;
        end else if (m_busy) begin
            if (bus.out_ready) begin
                m_busy = 0;
                if (m_pkts < 65535) m_pkts++;
                if (m_hold_err && m_tmos < 65535) m_tmos++;
            end
        end else if (m_pend) begin
            if (bus.CE) begin
                if (bus.INP_VALID[0]) m_a = bus.OPA;
                if (bus.INP_VALID[1]) m_b = bus.OPB;
                m_vm = m_vm | bus.INP_VALID;
                m_wait++;
                if (m_vm == 2'b11) emit(1'b0);
                else if (m_wait == TIMEOUT) emit(1'b1);
            end
        end else if (bus.CE && bus.INP_VALID != 2'b00) begin
            bit n2;
            logic [15:0] tbl;
            tbl    = bus.MODE ? ARITH : LOGIC;
            n2     = tbl[bus.CMD];
            m_a    = bus.INP_VALID[0] ? bus.OPA : 8'h00;
            m_b    = bus.INP_VALID[1] ? bus.OPB : 8'h00;
            m_vm   = bus.INP_VALID;
            m_cmd  = bus.CMD;
            m_mode = bus.MODE;
            m_cin  = bus.CIN;
            if (!n2 || bus.INP_VALID == 2'b11) emit(1'b0);
            else begin
                m_pend = 1; m_wait = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, update the model, advance past the edge.
    task automatic step(input bit rn, input bit ce, input logic [1:0] v,
                        input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                        input bit md, input bit ci, input bit ordy);
        rst_n = rn; bus.CE = ce; bus.INP_VALID = v; bus.OPA = a; bus.OPB = b;
        bus.CMD = c; bus.MODE = md; bus.CIN = ci; bus.out_ready = ordy;
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ce, input bit ordy);
        for (int i = 0; i < n; i++) step(1, ce, 2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, ordy);
    endtask

    task automatic check_reset_state();
        check("reset_outputs",
              {bus.out_valid, bus.out_opa, bus.out_opb, bus.out_cmd, bus.out_mode,
               bus.out_cin, bus.out_vmask, bus.out_err}, 64'h0);
        check("reset_in_ready", bus.in_ready, 1'b1);
    endtask

    // Monitor: compares presented packets and handshake-level status.
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", bus.in_ready, !m_busy);
`ifdef ALU_COLLECTOR_STATS_EN
            check("stat_pkt_cnt", stat_pkt_cnt, m_pkts);
            check("stat_tmo_cnt", stat_tmo_cnt, m_tmos);
`endif
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_packet", bus.out_valid, 1'b0);
                end else begin
                    check("packet",
                          {bus.out_opa, bus.out_opb, bus.out_cmd, bus.out_mode,
                           bus.out_cin, bus.out_vmask, bus.out_err},
                          {sb[0].opa, sb[0].opb, sb[0].cmd, sb[0].mode,
                           sb[0].cin, sb[0].vm, sb[0].err});
                    if (!seen) begin
                        check("valid_cycle", cyc, sb[0].exp_cyc);
                        seen = 1;
                    end
                    if (bus.out_ready) begin
                        $display("pkt cyc=%0d opa=%02h opb=%02h cmd=%0h mode=%0b cin=%0b vm=%02b err=%0b",
                                 cyc, bus.out_opa, bus.out_opb, bus.out_cmd, bus.out_mode,
                                 bus.out_cin, bus.out_vmask, bus.out_err);
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end else if (sb.size() > 0 && cyc >= sb[0].exp_cyc) begin
                check("late_packet", bus.out_valid, 1'b1);
            end
        end
    end

    initial begin
        rst_n = 1'b0; bus.CE = 1'b0; bus.INP_VALID = 2'b00; bus.OPA = 8'h00;
        bus.OPB = 8'h00; bus.CMD = 4'h0; bus.MODE = 1'b0; bus.CIN = 1'b0;
        bus.out_ready = 1'b0;
        m_busy = 0; m_pend = 0; m_hold_err = 0; m_pkts = 0; m_tmos = 0; m_wait = 0;
        m_a = 0; m_b = 0; m_cmd = 0; m_mode = 0; m_cin = 0; m_vm = 0;

        @(posedge clk); #1;
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        check_reset_state();
        mon_en = 1;

        // Reset in the middle of WAIT discards the partial packet.
        step(1, 1, 2'b01, 8'h33, 8'h00, 4'h0, 1, 0, 1);
        idle(1, 1, 1);
        step(0, 1, 2'b00, 0, 0, 0, 0, 0, 1);
        check_reset_state();
        idle(20, 1, 1);

        // Both operands together.
        step(1, 1, 2'b11, 8'h12, 8'h34, 4'h0, 1, 0, 1);
        idle(2, 1, 1);

        // Split arrival with OPA overwritten before OPB arrives.
        step(1, 1, 2'b01, 8'h05, 8'h00, 4'h3, 1, 1, 1);
        idle(2, 1, 1);
        step(1, 1, 2'b01, 8'h07, 8'h00, 4'h0, 0, 0, 1);
        idle(1, 1, 1);
        step(1, 1, 2'b10, 8'h00, 8'h09, 4'h0, 0, 0, 1);
        idle(2, 1, 1);

        // Timeout with CE high, then with CE low for 4 cycles.
        step(1, 1, 2'b10, 8'h00, 8'hAA, 4'h0, 1, 0, 1);
        idle(20, 1, 1);
        step(1, 1, 2'b10, 8'h00, 8'hAA, 4'h1, 1, 0, 1);
        for (int i = 0; i < 24; i++) idle(1, !(i >= 3 && i < 7), 1);

        // Single-operand logical command.
        step(1, 1, 2'b01, 8'h5C, 8'h00, 4'h8, 0, 1, 1);
        idle(2, 1, 1);

        // Backpressure: held packet ignores new input.
        step(1, 1, 2'b11, 8'hC3, 8'h3C, 4'h2, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 2'b11, 8'(i), 8'(i + 1), 4'h4, 0, 0, 0);
        idle(2, 1, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rn, ce, ordy;
            logic [1:0] v;
            rn   = ($urandom_range(0, 199) != 0);
            ce   = ($urandom_range(0, 9) != 0);
            ordy = ($urandom_range(0, 9) < 7);
            v    = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            step(rn, ce, v, 8'($urandom), 8'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), ordy);
        end

        // Drain any pending packet.
        idle(40, 1, 1);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
